// File: rtl/muldiv_pkg.sv
// Shared funct codes, FSM state and HI/LO write/read select encodings for the
// multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN
  } state_e;

  typedef enum logic [2:0] {
    WR_NONE,
    WR_UNIT,
    WR_MTHI,
    WR_MTLO,
    WR_DIVZ
  } hilo_wr_e;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_HI,
    RD_LO
  } hilo_rd_e;

  // Any of the six funct codes that touch the unit or HI/LO.
  function automatic logic is_hilo_fn(logic [5:0] f);
    return (f == FN_MULTU) || (f == FN_DIVU) || (f == FN_MFHI) ||
           (f == FN_MTHI)  || (f == FN_MFLO) || (f == FN_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Launch/completion handshake between the sequencer (master) and the iterative
// multiply/divide unit (slave).
interface muldiv_ctrl_if #(
  parameter int unsigned DW = 32
);
  logic          unit_start;
  logic          unit_op;
  logic [DW-1:0] unit_a;
  logic [DW-1:0] unit_b;
  logic          unit_done;
  logic [DW-1:0] unit_hi;
  logic [DW-1:0] unit_lo;

  modport master (
    output unit_start, unit_op, unit_a, unit_b,
    input  unit_done, unit_hi, unit_lo
  );

  modport slave (
    input  unit_start, unit_op, unit_a, unit_b,
    output unit_done, unit_hi, unit_lo
  );
endinterface

// File: rtl/hilo_regfile.sv
// HI/LO architectural registers: write-select mux (unit result, MTHI/MTLO,
// divide-by-zero) and the MFHI/MFLO read mux with optional result bypass.
module hilo_regfile
  import muldiv_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  hilo_wr_e      wr_sel_i,
  input  logic [DW-1:0] src_a_i,
  input  logic [DW-1:0] res_hi_i,
  input  logic [DW-1:0] res_lo_i,
  input  hilo_rd_e      rd_sel_i,
  input  logic          rd_byp_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    unique case (wr_sel_i)
      WR_NONE: ;
      WR_UNIT: begin
        hi_d = res_hi_i;
        lo_d = res_lo_i;
      end
      WR_MTHI: hi_d = src_a_i;
      WR_MTLO: lo_d = src_a_i;
      // Divide by zero: remainder is the dividend, quotient saturates.
      WR_DIVZ: begin
        hi_d = src_a_i;
        lo_d = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    unique case (rd_sel_i)
      RD_NONE: ;
      RD_HI:   rd_data_o = rd_byp_i ? res_hi_i : hi_q;
      RD_LO:   rd_data_o = rd_byp_i ? res_lo_i : lo_q;
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the iterative multiply/divide unit; owns HI/LO.
// Optional macro HILO_FWD_EN: forward the unit result to MFHI/MFLO in the done cycle.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CW      = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [5:0]    funct,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  output logic          stall,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          timeout_err,
  muldiv_ctrl_if.master unit
);

`ifdef HILO_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  state_e        state_q, state_d;
  logic          op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  hilo_wr_e      wr_sel;
  hilo_rd_e      rd_sel;
  logic          done_fire;
  logic          rd_byp;
  logic          fwd_rd;

  assign busy            = (state_q != ST_IDLE);
  assign timeout_err     = timeout_q;
  assign unit.unit_start = (state_q == ST_LAUNCH);
  assign unit.unit_op    = op_q;
  assign unit.unit_a     = a_q;
  assign unit.unit_b     = b_q;

  // Done only counts while a unit op is actually in flight.
  assign done_fire = (state_q == ST_RUN) && unit.unit_done;
  assign rd_byp    = FwdEn && done_fire;
  assign fwd_rd    = rd_byp && issue_valid && ((funct == FN_MFHI) || (funct == FN_MFLO));
  assign stall     = issue_valid && is_hilo_fn(funct) && busy && !fwd_rd;

  always_comb begin
    rd_sel = RD_NONE;
    if (funct == FN_MFHI) begin
      rd_sel = RD_HI;
    end else if (funct == FN_MFLO) begin
      rd_sel = RD_LO;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    wr_sel    = WR_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (issue_valid) begin
          case (funct)
            FN_MULTU: begin
              op_d    = OP_MUL;
              a_d     = src_a;
              b_d     = src_b;
              state_d = ST_LAUNCH;
            end
            FN_DIVU: begin
              if (src_b != '0) begin
                op_d    = OP_DIV;
                a_d     = src_a;
                b_d     = src_b;
                state_d = ST_LAUNCH;
              end else begin
                wr_sel = WR_DIVZ;
              end
            end
            FN_MTHI: wr_sel = WR_MTHI;
            FN_MTLO: wr_sel = WR_MTLO;
            default: ;
          endcase
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (unit.unit_done) begin
          wr_sel  = WR_UNIT;
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Unit hung: abandon the op, leave HI/LO untouched.
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  hilo_regfile #(
    .DW (DW)
  ) u_hilo (
    .clk_i     (clk),
    .rst_ni    (reset),
    .wr_sel_i  (wr_sel),
    .src_a_i   (src_a),
    .res_hi_i  (unit.unit_hi),
    .res_lo_i  (unit.unit_lo),
    .rd_sel_i  (rd_sel),
    .rd_byp_i  (rd_byp),
    .rd_data_o (rd_data)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural unit model with configurable latency, a table of
// single-cycle HI/LO ops, hand-written multi-cycle sequences and randomized ops.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b;
  logic        stall, busy, timeout_err;
  logic [31:0] rd_data;

  muldiv_ctrl_if #(.DW(32)) u_if ();

  muldiv_ctrl #(.DW(32), .TIMEOUT(40), .CW(6)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .funct       (funct),
    .src_a       (src_a),
    .src_b       (src_b),
    .stall       (stall),
    .rd_data     (rd_data),
    .busy        (busy),
    .timeout_err (timeout_err),
    .unit        (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit model: responds lat_cfg cycles after the start pulse with the true result.
  int          lat_cfg;
  bit          never_done;
  logic        t_done;
  logic        m_done;
  logic [31:0] m_hi, m_lo, ma, mb;
  logic        mop;
  int          cd;

  assign u_if.unit_done = m_done | t_done;
  assign u_if.unit_hi   = m_hi;
  assign u_if.unit_lo   = m_lo;

  initial begin
    cd = 0; m_done = 1'b0; m_hi = '0; m_lo = '0; ma = '0; mb = '0; mop = 1'b0;
  end

  always @(negedge clk) begin
    m_done <= 1'b0;
    if (u_if.unit_start) begin
      cd  <= lat_cfg;
      ma  <= u_if.unit_a;
      mb  <= u_if.unit_b;
      mop <= u_if.unit_op;
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1 && !never_done) begin
        m_done <= 1'b1;
        if (mop) begin
          m_hi <= ma % mb;
          m_lo <= ma / mb;
        end else begin
          {m_hi, m_lo} <= {32'b0, ma} * {32'b0, mb};
        end
      end
    end
  end

  int n_pass, n_tot;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic read_hilo(input logic [31:0] eh, input logic [31:0] el, input string tag);
    @(negedge clk);
    issue_valid = 1'b1; funct = FN_MFHI;
    #2;
    chk({tag, " mfhi stall"}, {31'b0, stall}, 32'd0);
    chk({tag, " mfhi"}, rd_data, eh);
    @(negedge clk);
    funct = FN_MFLO;
    #2;
    chk({tag, " mflo"}, rd_data, el);
    @(negedge clk);
    issue_valid = 1'b0; funct = '0;
  endtask

  // Issue one instruction from IDLE and follow it until the controller is idle again.
  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output int busy_n, output int starts,
                        output logic [31:0] sa, output logic [31:0] sb, output logic sop);
    bit idle_seen;
    @(negedge clk);
    issue_valid = 1'b1; funct = fn; src_a = a; src_b = b;
    #2;
    chk("issue stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    issue_valid = 1'b0;
    busy_n = 0; starts = 0; sa = '0; sb = '0; sop = 1'b0; idle_seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      #2;
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
      busy_n++;
      if (u_if.unit_start) begin
        starts++;
        sa = u_if.unit_a; sb = u_if.unit_b; sop = u_if.unit_op;
      end
      @(negedge clk);
    end
    if (!idle_seen) chk("busy timeout bound", 32'd1, 32'd0);
  endtask

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        tbl[6];
  int          bn, st, stalled, idx;
  logic [31:0] sa, sb, ra, rb, exp_hi, exp_lo;
  logic        sop, got;
  logic [63:0] prod;
  int          sel;
  bit          launched;
  logic [5:0]  rfn;

  initial begin
    tbl[0] = '{FN_DIVU,  32'd100,       32'd0, 32'd100,       32'hFFFF_FFFF};
    tbl[1] = '{FN_MTHI,  32'hDEAD_BEEF, 32'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    tbl[2] = '{FN_MTLO,  32'h0BAD_F00D, 32'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    tbl[3] = '{6'b100000, 32'h5555,     32'd7, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    tbl[4] = '{FN_MFHI,  32'd1,         32'd2, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    tbl[5] = '{FN_DIVU,  32'd0,         32'd0, 32'd0,         32'hFFFF_FFFF};

    n_pass = 0; n_tot = 0;
    lat_cfg = 33; never_done = 1'b0; t_done = 1'b0;
    reset = 1'b0; issue_valid = 1'b0; funct = FN_MFHI; src_a = '0; src_b = '0;

    // Reset state
    @(negedge clk);
    #2;
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst start", {31'b0, u_if.unit_start}, 32'd0);
    chk("rst unit_a", u_if.unit_a, 32'd0);
    chk("rst timeout", {31'b0, timeout_err}, 32'd0);
    chk("rst rd_data", rd_data, 32'd0);
    @(negedge clk);
    reset = 1'b1; funct = '0;

    // 7 * 6 with 33-cycle unit
    run_op(FN_MULTU, 32'd7, 32'd6, bn, st, sa, sb, sop);
    chk("t1 busy cycles", bn, 32'd34);
    chk("t1 start pulses", st, 32'd1);
    chk("t1 unit_a", sa, 32'd7);
    chk("t1 unit_b", sb, 32'd6);
    chk("t1 unit_op", {31'b0, sop}, 32'd0);
    read_hilo(32'd0, 32'd42, "t1");

    // MFHI arriving 5 cycles after a multiply
    @(negedge clk);
    issue_valid = 1'b1; funct = FN_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
    #2;
    chk("t2 issue stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (4) @(negedge clk);
    issue_valid = 1'b1; funct = FN_MFHI;
    stalled = 0; got = 1'b0;
    for (int k = 0; k < 80; k++) begin
      #2;
      if (!stall) begin
        got = 1'b1;
        break;
      end
      stalled++;
      @(negedge clk);
    end
    chk("t2 stall released", {31'b0, got}, 32'd1);
    chk("t2 stall cycles", stalled, FWD ? 32'd29 : 32'd30);
    chk("t2 mfhi", rd_data, 32'd1);
    @(negedge clk);
    issue_valid = 1'b0; funct = '0;
    read_hilo(32'd1, 32'hFFFF_FFFE, "t2");

    // Single-cycle HI/LO ops from IDLE, including divide by zero
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].fn, tbl[i].a, tbl[i].b, bn, st, sa, sb, sop);
      chk($sformatf("tbl%0d busy", i), bn, 32'd0);
      chk($sformatf("tbl%0d start", i), st, 32'd0);
      read_hilo(tbl[i].hi, tbl[i].lo, $sformatf("tbl%0d", i));
    end

    // Watchdog: unit never answers
    never_done = 1'b1;
    run_op(FN_MULTU, 32'd9, 32'd9, bn, st, sa, sb, sop);
    chk("t4 busy cycles", bn, 32'd41);
    chk("t4 timeout_err", {31'b0, timeout_err}, 32'd1);
    read_hilo(32'd0, 32'hFFFF_FFFF, "t4 kept");
    run_op(FN_MTLO, 32'd5, 32'd0, bn, st, sa, sb, sop);
    read_hilo(32'd0, 32'd5, "t4 mtlo");
    chk("t4 timeout sticky", {31'b0, timeout_err}, 32'd1);
    repeat (5) @(negedge clk);

    // Reset in the middle of a divide, then a late done
    @(negedge clk);
    issue_valid = 1'b1; funct = FN_DIVU; src_a = 32'd8; src_b = 32'd2;
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (11) @(negedge clk);
    #2;
    chk("t5 unit_op before reset", {31'b0, u_if.unit_op}, 32'd1);
    @(negedge clk);
    reset = 1'b0; issue_valid = 1'b1; funct = FN_MFHI;
    #2;
    chk("t5 busy", {31'b0, busy}, 32'd0);
    chk("t5 stall", {31'b0, stall}, 32'd0);
    chk("t5 unit_op", {31'b0, u_if.unit_op}, 32'd0);
    chk("t5 unit_a", u_if.unit_a, 32'd0);
    chk("t5 unit_b", u_if.unit_b, 32'd0);
    chk("t5 timeout", {31'b0, timeout_err}, 32'd0);
    chk("t5 rd_data", rd_data, 32'd0);
    @(negedge clk);
    reset = 1'b1; issue_valid = 1'b0; funct = '0;
    repeat (19) @(negedge clk);
    t_done = 1'b1;
    #2;
    chk("t5 late done busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    t_done = 1'b0;
    #2;
    chk("t5 late done start", {31'b0, u_if.unit_start}, 32'd0);
    repeat (10) @(negedge clk);
    never_done = 1'b0;
    read_hilo(32'd0, 32'd0, "t5");

    // Back-to-back multiply then divide
    lat_cfg = 33;
    @(negedge clk);
    issue_valid = 1'b1; funct = FN_MULTU; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    funct = FN_DIVU; src_a = 32'd13; src_b = 32'd5;
    idx = 1; got = 1'b0;
    for (int k = 0; k < 80; k++) begin
      #2;
      if (!stall) begin
        got = 1'b1;
        break;
      end
      idx++;
      @(negedge clk);
    end
    chk("t6 second issue cycle", idx, 32'd35);
    chk("t6 idle start", {31'b0, u_if.unit_start}, 32'd0);
    @(negedge clk);
    issue_valid = 1'b0; funct = '0;
    #2;
    chk("t6 second start", {31'b0, u_if.unit_start}, 32'd1);
    chk("t6 unit_op", {31'b0, u_if.unit_op}, 32'd1);
    chk("t6 unit_a", u_if.unit_a, 32'd13);
    chk("t6 unit_b", u_if.unit_b, 32'd5);
    chk("t6 mid hi", u_dut.u_hilo.hi_q, 32'd0);
    chk("t6 mid lo", u_dut.u_hilo.lo_q, 32'd12);
    got = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      #2;
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    chk("t6 finished", {31'b0, got}, 32'd1);
    read_hilo(32'd3, 32'd2, "t6");

    // Randomized ops against arithmetic reference
    exp_hi = 32'd3; exp_lo = 32'd2;
    for (int r = 0; r < 24; r++) begin
      sel = $urandom_range(0, 3);
      ra = $urandom; rb = $urandom;
      if (sel == 1 && $urandom_range(0, 4) == 0) rb = '0;
      lat_cfg = $urandom_range(1, 38);
      rfn = (sel == 0) ? FN_MULTU : (sel == 1) ? FN_DIVU : (sel == 2) ? FN_MTHI : FN_MTLO;
      launched = (sel == 0) || (sel == 1 && rb != 0);
      run_op(rfn, ra, rb, bn, st, sa, sb, sop);
      if (sel == 0) begin
        prod = 64'(ra) * 64'(rb);
        exp_hi = prod[63:32]; exp_lo = prod[31:0];
      end else if (sel == 1) begin
        if (rb == 0) begin
          exp_hi = ra; exp_lo = 32'hFFFF_FFFF;
        end else begin
          exp_hi = ra % rb; exp_lo = ra / rb;
        end
      end else if (sel == 2) begin
        exp_hi = ra;
      end else begin
        exp_lo = ra;
      end
      chk($sformatf("rnd%0d busy", r), bn, launched ? 32'(lat_cfg + 1) : 32'd0);
      read_hilo(exp_hi, exp_lo, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
